// File: rtl/led_breath_pwm.sv
// led_breath_pwm: drives the board LEDs from the colour rotator's active-low
// pattern. With en = 1 each enabled channel gets a triangular "breathing" PWM
// envelope. With en = 0 the pattern is passed straight through, one cycle late.
//
// Handshake: none. led_in is a level that is sampled on every clock edge.
// Any change in the pattern while en = 1 restarts the envelope from zero.
// The envelope state is visible on the phase output (0 = RAMP_UP, 1 = RAMP_DOWN)
// and on the duty output.
module led_breath_pwm #(
    parameter int PRESC        = 4,
    parameter int STEP_PERIODS = 26
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic [2:0] led_in,
    output logic [2:0] led_out,
    output logic [7:0] duty,
    output logic       phase
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_PERIODS - 1);

    localparam logic [0:0] RAMP_UP   = 1'b0;
    localparam logic [0:0] RAMP_DOWN = 1'b1;

    logic [PW-1:0] presc_cnt;
    logic [7:0]    pwm_cnt;
    logic [SW-1:0] per_cnt;
    logic [2:0]    led_q;
    logic [0:0]    state;

    logic tick;
    logic period_end;
    logic step;
    logic restart;
    logic hold;
    logic lit;

    // A pattern change restarts the envelope, and it takes priority over any
    // step or period end that falls on the same edge.
    assign restart    = en && (led_in != led_q);
    assign hold       = !en || restart;
    assign tick       = (presc_cnt == PRESC_LAST);
    assign period_end = tick && (pwm_cnt == 8'd255);
    assign step       = period_end && (per_cnt == STEP_LAST);
    assign lit        = (pwm_cnt < duty);
    assign phase      = state[0];

    // Prescaler: divides sys_clk down to the PWM tick rate.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)       presc_cnt <= '0;
        else if (hold)     presc_cnt <= '0;
        else if (tick)     presc_cnt <= '0;
        else               presc_cnt <= presc_cnt + 1'b1;
    end

    // PWM counter: one 8-bit ramp per period. The 255 -> 0 wrap is natural.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)       pwm_cnt <= '0;
        else if (hold)     pwm_cnt <= '0;
        else if (tick)     pwm_cnt <= pwm_cnt + 8'd1;
    end

    // Period counter: counts whole PWM periods between duty steps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)          per_cnt <= '0;
        else if (hold)        per_cnt <= '0;
        else if (step)        per_cnt <= '0;
        else if (period_end)  per_cnt <= per_cnt + 1'b1;
    end

    // Envelope FSM: one duty LSB per step. Turns around at 255 and at 0, so
    // each extreme is held for exactly one step interval.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            duty  <= 8'd0;
            state <= RAMP_UP;
        end else if (hold) begin
            duty  <= 8'd0;
            state <= RAMP_UP;
        end else if (step) begin
            case (state)
                RAMP_UP: begin
                    duty <= duty + 8'd1;
                    if (duty == 8'd254) state <= RAMP_DOWN;
                end
                default: begin
                    duty <= duty - 8'd1;
                    if (duty == 8'd1) state <= RAMP_UP;
                end
            endcase
        end
    end

    // Last accepted pattern. It is used to detect pattern changes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)   led_q <= 3'b111;
        else if (hold) led_q <= led_in;
    end

    // Registered LED drive: bypass, dark on restart, otherwise gated by the PWM.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)       led_out <= 3'b111;
        else if (!en)      led_out <= led_in;
        else if (restart)  led_out <= 3'b111;
        else               led_out <= led_in | {3{~lit}};
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm: checks led_breath_pwm against an elapsed-time model of
// the breathing envelope. Small parameters keep the envelope short.
module tb_led_breath_pwm;

    localparam int P_PRESC = 1;
    localparam int P_STEP  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] led_in;
    logic [2:0] led_out;
    logic [7:0] duty;
    logic       phase;

    int n_vec  = 0;
    int n_fail = 0;

    led_breath_pwm #(.PRESC(P_PRESC), .STEP_PERIODS(P_STEP)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .en      (en),
        .led_in  (led_in),
        .led_out (led_out),
        .duty    (duty),
        .phase   (phase)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Model: m_n counts the enabled edges since the last restart. Everything
    // else is derived from m_n with plain arithmetic.
    longint     m_n   = 0;
    logic [2:0] m_q   = 3'b111;
    logic [2:0] m_out = 3'b111;

    function automatic longint env_pos(longint n);
        longint t;
        t = n / P_PRESC;
        return ((t / 256) / P_STEP) % 510;
    endfunction

    function automatic int exp_duty(longint n);
        longint s;
        s = env_pos(n);
        return (s <= 255) ? int'(s) : int'(510 - s);
    endfunction

    function automatic int exp_phase(longint n);
        return (env_pos(n) >= 255) ? 1 : 0;
    endfunction

    function automatic int exp_pwm(longint n);
        return int'((n / P_PRESC) % 256);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n   <= 0;
            m_q   <= 3'b111;
            m_out <= 3'b111;
        end else if (!en) begin
            m_n   <= 0;
            m_q   <= led_in;
            m_out <= led_in;
        end else if (led_in != m_q) begin
            m_n   <= 0;
            m_q   <= led_in;
            m_out <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++)
                m_out[i] <= (led_in[i] == 1'b0 && exp_pwm(m_n) < exp_duty(m_n)) ? 1'b0 : 1'b1;
            m_n <= m_n + 1;
        end
    end

    // Scoreboard check.
    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, sampled on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("led_out", int'(led_out), int'(m_out));
            check("duty",    int'(duty),    exp_duty(m_n));
            check("phase",   int'(phase),   exp_phase(m_n));
        end
    end

    // Driver: advance k rising edges, then step just past the last edge.
    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    int zeros;
    int run;
    int max_run;
    int upper_bad;

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        led_in = 3'b111;
        edges(3);
        check("rst_led",   int'(led_out), 7);
        check("rst_duty",  int'(duty),    0);
        check("rst_phase", int'(phase),   0);

        // Bypass.
        rst    = 1'b0;
        led_in = 3'b110;
        edges(1);
        check("byp_a", int'(led_out), 6);
        led_in = 3'b101;
        edges(1);
        check("byp_b",    int'(led_out), 5);
        check("byp_duty", int'(duty),    0);

        // Enable with a new pattern. This first edge is a restart.
        en     = 1'b1;
        led_in = 3'b110;
        edges(1);
        check("en_led",  int'(led_out), 7);
        check("en_duty", int'(duty),    0);
        edges(3 * 256);
        check("ramp3", int'(duty), 3);

        // Asynchronous reset in the middle of the ramp. It acts before the next edge.
        #2 rst = 1'b1;
        #1;
        check("arst_led",   int'(led_out), 7);
        check("arst_duty",  int'(duty),    0);
        check("arst_phase", int'(phase),   0);
        edges(2);
        rst = 1'b0;
        // led_q is 111 after reset and led_in is 110, so the next edge restarts.
        edges(1);
        // Duty is 0 for the first period, so channel 0 must stay dark.
        zeros = 0;
        for (int k = 0; k < 255; k++) begin
            edges(1);
            if (led_out != 3'b111) zeros++;
        end
        check("first_period_dark", zeros, 0);
        check("pre_step_duty", int'(duty), 0);
        edges(1);
        check("first_step", int'(duty), 1);

        // Count lit cycles over the period where duty is 64.
        edges(64 * 256 - 256);
        check("duty64", int'(duty), 64);
        zeros = 0; run = 0; max_run = 0; upper_bad = 0;
        for (int k = 0; k < 256; k++) begin
            edges(1);
            if (led_out[0] == 1'b0) begin
                zeros++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (led_out[2:1] != 2'b11) upper_bad++;
        end
        check("duty64_zeros", zeros,     64);
        check("duty64_run",   max_run,   64);
        check("duty64_upper", upper_bad, 0);

        // Peak and turnaround.
        edges(255 * 256 - 65 * 256);
        check("peak_duty",  int'(duty),  255);
        check("peak_phase", int'(phase), 1);
        edges(256);
        check("down_duty",  int'(duty),  254);
        check("down_phase", int'(phase), 1);

        // Pattern change on the same edge as a step: the restart must win.
        edges(255);
        led_in = 3'b101;
        edges(1);
        check("coinc_duty",  int'(duty),    0);
        check("coinc_phase", int'(phase),   0);
        check("coinc_led",   int'(led_out), 7);
        edges(257);
        check("chg_duty", int'(duty),    1);
        check("chg_led",  int'(led_out), 5);

        // Random pattern and enable changes.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) led_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) en = ~en;
            edges(1);
        end
        en     = 1'b1;
        led_in = 3'b000;
        edges(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
